// File: rtl/truth_table_sweeper_pkg.sv
// Shared types for the truth-table sweeper: FSM encoding and vector-count helper.
package truth_table_sweeper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    function automatic int nvec(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// Loadable down-counter that flags when a vector has been held long enough.
module settle_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps all input vectors over a gate pair, captures both truth tables
// and counts the vectors on which the two implementations disagree.
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic [N_IN-1:0]        x,
    input  logic                   sa,
    input  logic                   sb,
    output logic                   busy,
    output logic                   done,
    output logic [(1<<N_IN)-1:0]   table_a,
    output logic [(1<<N_IN)-1:0]   table_b,
    output logic                   mismatch,
    output logic [N_IN:0]          err_count
);

    localparam int NVEC  = nvec(N_IN);
    // A zero settle time would sample the same edge x changes; clamp to one.
    localparam int S_EFF = (SETTLE < 1) ? 1 : SETTLE;
    localparam int CW    = (S_EFF > 1) ? $clog2(S_EFF) : 1;
    localparam logic [CW-1:0] LOAD = CW'(S_EFF - 1);

    state_t state, state_nx;
    logic   t_load, t_dec, t_zero;
    logic   clr, cap, x_inc;
    logic   last;

    assign last = (x == N_IN'(NVEC - 1));

    settle_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (t_load),
        .load_val (LOAD),
        .dec      (t_dec),
        .zero     (t_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        t_load   = 1'b0;
        t_dec    = 1'b0;
        clr      = 1'b0;
        cap      = 1'b0;
        x_inc    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    clr      = 1'b1;
                    t_load   = 1'b1;
                    state_nx = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (t_zero) state_nx = ST_SAMPLE;
                else        t_dec    = 1'b1;
            end
            ST_SAMPLE: begin
                cap = 1'b1;
                if (last) begin
                    state_nx = ST_DONE;
                end else begin
                    x_inc    = 1'b1;
                    t_load   = 1'b1;
                    state_nx = ST_SETTLE;
                end
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x         <= '0;
            table_a   <= '0;
            table_b   <= '0;
            mismatch  <= 1'b0;
            err_count <= '0;
        end else if (clr) begin
            x         <= '0;
            table_a   <= '0;
            table_b   <= '0;
            mismatch  <= 1'b0;
            err_count <= '0;
        end else begin
            if (cap) begin
                table_a[x] <= sa;
                table_b[x] <= sb;
                if (sa != sb) begin
                    err_count <= err_count + (N_IN+1)'(1);
                    mismatch  <= 1'b1;
                end
            end
            if (x_inc) x <= x + N_IN'(1);
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: sweeps s = a | ~b through two sweeper builds (SETTLE 1 and 3).
module tb_truth_table_sweeper;

    logic       clk = 1'b0;
    logic       reset;
    logic       start1, start3;
    logic       faulty;
    logic [1:0] x1, x3;
    logic       sa1, sb1, sa3, sb3;
    logic       busy1, busy3, done1, done3;
    logic [3:0] ta1, tb1, ta3, tb3;
    logic       mm1, mm3;
    logic [2:0] ec1, ec3;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0] ta;
        logic [3:0] tb;
        logic [2:0] ec;
        logic       mm;
        int         lat;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    // gate pair: a = x[1], b = x[0]
    assign sa1 = x1[1] | ~x1[0];
    assign sb1 = faulty ? (x1[1] & x1[0]) : (x1[1] | ~x1[0]);
    assign sa3 = x3[1] | ~x3[0];
    assign sb3 = x3[1] | ~x3[0];

    truth_table_sweeper #(.N_IN(2), .SETTLE(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .x(x1),
        .sa(sa1), .sb(sb1), .busy(busy1), .done(done1),
        .table_a(ta1), .table_b(tb1), .mismatch(mm1), .err_count(ec1)
    );

    truth_table_sweeper #(.N_IN(2), .SETTLE(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .x(x3),
        .sa(sa3), .sb(sb3), .busy(busy3), .done(done3),
        .table_a(ta3), .table_b(tb3), .mismatch(mm3), .err_count(ec3)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic get(input int w, output logic [1:0] x, output logic bz,
                       output logic dn, output logic [3:0] ta,
                       output logic [3:0] tb, output logic mm,
                       output logic [2:0] ec);
        if (w == 3) begin
            x = x3; bz = busy3; dn = done3; ta = ta3; tb = tb3;
            mm = mm3; ec = ec3;
        end else begin
            x = x1; bz = busy1; dn = done1; ta = ta1; tb = tb1;
            mm = mm1; ec = ec1;
        end
    endtask

    task automatic set_start(input int w, input logic v);
        if (w == 3) start3 = v;
        else        start1 = v;
    endtask

    task automatic push_exp(input int settle, input logic bad);
        exp_t e;
        logic a, b, ga, gb;
        e.ta = '0; e.tb = '0; e.ec = '0; e.mm = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a  = (i >= 2);
            b  = (i % 2 == 1);
            ga = a | ~b;
            gb = bad ? (a & b) : ga;
            e.ta[i] = ga;
            e.tb[i] = gb;
            if (ga != gb) begin
                e.ec = e.ec + 3'd1;
                e.mm = 1'b1;
            end
        end
        e.lat = 4 * (settle + 1);
        sb_q.push_back(e);
    endtask

    // Pulses start, follows x each cycle, then pops and checks the result.
    task automatic run_sweep(input int w, input logic bad,
                             input logic repulse, input logic hold);
        exp_t e;
        logic [1:0] x;
        logic bz, dn, mm;
        logic [3:0] ta, tb;
        logic [2:0] ec;
        int c, xe, limit;
        bit seen;
        push_exp(w, bad);
        @(negedge clk);
        set_start(w, 1'b1);
        @(negedge clk);
        if (!hold) set_start(w, 1'b0);
        seen  = 1'b0;
        limit = 4 * (w + 1) + 6;
        c = 1;
        while (c <= limit && !seen) begin
            get(w, x, bz, dn, ta, tb, mm, ec);
            xe = (c - 1) / (w + 1);
            if (xe > 3) xe = 3;
            chk($sformatf("x_s%0d_c%0d", w, c), 32'(x), 32'(xe));
            if (dn) begin
                seen = 1'b1;
            end else begin
                if (!hold) set_start(w, repulse && c <= 2);
                @(negedge clk);
                c++;
            end
        end
        e = sb_q.pop_front();
        chk($sformatf("done_seen_s%0d", w), 32'(seen), 32'd1);
        if (seen) begin
            chk("latency",   32'(c - 1), 32'(e.lat));
            chk("busy_done", 32'(bz),    32'd1);
            chk("table_a",   32'(ta),    32'(e.ta));
            chk("table_b",   32'(tb),    32'(e.tb));
            chk("err_count", 32'(ec),    32'(e.ec));
            chk("mismatch",  32'(mm),    32'(e.mm));
        end
        @(negedge clk);
        get(w, x, bz, dn, ta, tb, mm, ec);
        chk("done_pulse", 32'(dn), 32'd0);
        chk("idle_busy",  32'(bz), 32'd0);
        chk("hold_ta",    32'(ta), 32'(e.ta));
        chk("hold_ec",    32'(ec), 32'(e.ec));
    endtask

    initial begin
        logic [1:0] x;
        logic bz, dn, mm;
        logic [3:0] ta, tb;
        logic [2:0] ec;
        int guard;
        bit got_done;

        reset  = 1'b1;
        start1 = 1'b0;
        start3 = 1'b0;
        faulty = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        get(1, x, bz, dn, ta, tb, mm, ec);
        chk("rst_x",    32'(x),  32'd0);
        chk("rst_busy", 32'(bz), 32'd0);
        chk("rst_done", 32'(dn), 32'd0);
        chk("rst_ta",   32'(ta), 32'd0);
        chk("rst_tb",   32'(tb), 32'd0);
        chk("rst_mm",   32'(mm), 32'd0);
        chk("rst_ec",   32'(ec), 32'd0);

        run_sweep(1, 1'b0, 1'b0, 1'b0);

        faulty = 1'b1;
        run_sweep(1, 1'b1, 1'b0, 1'b0);
        faulty = 1'b0;

        run_sweep(1, 1'b0, 1'b1, 1'b0);
        got_done = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done1) got_done = 1'b1;
        end
        chk("no_extra_done", 32'(got_done), 32'd0);

        // reset mid-sweep once x reaches 2
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        guard = 0;
        while (x1 != 2'd2 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("reach_x2", 32'(x1), 32'd2);
        reset = 1'b1;
        #1;
        get(1, x, bz, dn, ta, tb, mm, ec);
        chk("arst_x",    32'(x),  32'd0);
        chk("arst_busy", 32'(bz), 32'd0);
        chk("arst_ta",   32'(ta), 32'd0);
        chk("arst_ec",   32'(ec), 32'd0);
        got_done = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (done1) got_done = 1'b1;
        end
        reset = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done1) got_done = 1'b1;
        end
        chk("arst_no_done", 32'(got_done), 32'd0);
        run_sweep(1, 1'b0, 1'b0, 1'b0);

        // start held high: restart on the first IDLE cycle after DONE
        faulty = 1'b1;
        push_exp(1, 1'b1);
        @(negedge clk);
        start1 = 1'b1;
        guard = 0;
        while (!done1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("held_done", 32'(done1), 32'd1);
        @(negedge clk);
        chk("held_idle", 32'(busy1), 32'd0);
        @(negedge clk);
        chk("held_restart", 32'(busy1), 32'd1);
        start1 = 1'b0;
        guard = 0;
        while (!done1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("held_done2", 32'(done1), 32'd1);
        begin
            exp_t e;
            e = sb_q.pop_front();
            chk("held_ec", 32'(ec1), 32'(e.ec));
            chk("held_tb", 32'(tb1), 32'(e.tb));
        end
        faulty = 1'b0;
        repeat (2) @(negedge clk);

        run_sweep(3, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
